// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter
// Two-requester Avalon-MM arbiter in front of the single SDRAM-controller
// slave. Requester 0 is the manual switch/KEY master, requester 1 is the GPU
// draw/framebuffer engine. Grants are round-robin, one transfer per grant.
// A small tag FIFO remembers which requester issued each accepted read so
// that every returning readdatavalid is routed to the right requester.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   rqN_*  (N = 0, 1)            requester-side Avalon-MM slave ports
//   avm_*                        master port towards the SDRAM controller
//   pending_count                number of accepted reads still awaiting data
//   err_unexpected_rdv           sticky: read data arrived with no tag queued
module sdram_req_arbiter #(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32,
    parameter int MAX_PENDING  = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    // requester 0
    input  logic [ADDRESSWIDTH-1:0]        rq0_address,
    input  logic                           rq0_read,
    input  logic                           rq0_write,
    input  logic [DATAWIDTH-1:0]           rq0_writedata,
    input  logic [DATAWIDTH/8-1:0]         rq0_byteenable,
    output logic                           rq0_waitrequest,
    output logic [DATAWIDTH-1:0]           rq0_readdata,
    output logic                           rq0_readdatavalid,
    // requester 1
    input  logic [ADDRESSWIDTH-1:0]        rq1_address,
    input  logic                           rq1_read,
    input  logic                           rq1_write,
    input  logic [DATAWIDTH-1:0]           rq1_writedata,
    input  logic [DATAWIDTH/8-1:0]         rq1_byteenable,
    output logic                           rq1_waitrequest,
    output logic [DATAWIDTH-1:0]           rq1_readdata,
    output logic                           rq1_readdatavalid,
    // SDRAM slave
    output logic [ADDRESSWIDTH-1:0]        avm_address,
    output logic [DATAWIDTH-1:0]           avm_writedata,
    output logic [DATAWIDTH/8-1:0]         avm_byteenable,
    output logic                           avm_read,
    output logic                           avm_write,
    input  logic                           avm_waitrequest,
    input  logic [DATAWIDTH-1:0]           avm_readdata,
    input  logic                           avm_readdatavalid,
    // status
    output logic [$clog2(MAX_PENDING):0]   pending_count,
    output logic                           err_unexpected_rdv
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state_r, state_next_s;
    logic                   owner_r, owner_next_s;
    logic                   last_r, last_next_s;
    logic [MAX_PENDING-1:0] tag_fifo_r;
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]       pending_count_r;
    logic                   err_r;

    logic                   fifo_full_s, fifo_empty_s;
    logic                   elig0_s, elig1_s;
    logic                   sel_read_s, sel_write_s;
    logic                   push_s, pop_s, head_tag_s;

    assign fifo_full_s  = (pending_count_r == CNT_MAX);
    assign fifo_empty_s = (pending_count_r == {CNT_W{1'b0}});

    // A read only competes when the tag FIFO has room for its tag.
    assign elig0_s = rq0_write | (rq0_read & ~fifo_full_s);
    assign elig1_s = rq1_write | (rq1_read & ~fifo_full_s);

    assign sel_read_s  = owner_r ? rq1_read  : rq0_read;
    assign sel_write_s = owner_r ? rq1_write : rq0_write;

    // Data path follows the owner; strobes alone qualify the transfer.
    assign avm_address    = owner_r ? rq1_address    : rq0_address;
    assign avm_writedata  = owner_r ? rq1_writedata  : rq0_writedata;
    assign avm_byteenable = owner_r ? rq1_byteenable : rq0_byteenable;

    // Read return path: data is broadcast, valid goes to the head tag owner.
    assign pop_s             = avm_readdatavalid & ~fifo_empty_s;
    assign head_tag_s        = tag_fifo_r[rd_ptr_r];
    assign rq0_readdata      = avm_readdata;
    assign rq1_readdata      = avm_readdata;
    assign rq0_readdatavalid = pop_s & ~head_tag_s;
    assign rq1_readdatavalid = pop_s &  head_tag_s;

    assign pending_count      = pending_count_r;
    assign err_unexpected_rdv = err_r;

    // Next-state, grant and strobe decode for the IDLE/BUSY arbiter.
    always_comb begin
        state_next_s    = state_r;
        owner_next_s    = owner_r;
        last_next_s     = last_r;
        avm_read        = 1'b0;
        avm_write       = 1'b0;
        rq0_waitrequest = 1'b1;
        rq1_waitrequest = 1'b1;
        push_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (elig0_s && elig1_s) begin
                    owner_next_s = ~last_r;
                    state_next_s = ST_BUSY;
                end else if (elig0_s) begin
                    owner_next_s = 1'b0;
                    state_next_s = ST_BUSY;
                end else if (elig1_s) begin
                    owner_next_s = 1'b1;
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Write wins when the owner raises both strobes.
                avm_write = sel_write_s;
                avm_read  = sel_read_s & ~sel_write_s;
                if (owner_r) begin
                    rq1_waitrequest = avm_waitrequest;
                end else begin
                    rq0_waitrequest = avm_waitrequest;
                end
                if ((sel_read_s | sel_write_s) && !avm_waitrequest) begin
                    last_next_s  = owner_r;
                    state_next_s = ST_IDLE;
                    push_s       = ~sel_write_s;
                end else if (!(sel_read_s | sel_write_s)) begin
                    // Owner withdrew its request: release without a transfer.
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Arbiter state register; requester 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            owner_r <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_next_s;
            owner_r <= owner_next_s;
            last_r  <= last_next_s;
        end
    end

    // Read tag FIFO, outstanding-read counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_fifo_r      <= {MAX_PENDING{1'b0}};
            wr_ptr_r        <= {PTR_W{1'b0}};
            rd_ptr_r        <= {PTR_W{1'b0}};
            pending_count_r <= {CNT_W{1'b0}};
            err_r           <= 1'b0;
        end else begin
            if (push_s) begin
                tag_fifo_r[wr_ptr_r] <= owner_r;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   pending_count_r <= pending_count_r + CNT_ONE;
                2'b01:   pending_count_r <= pending_count_r - CNT_ONE;
                default: pending_count_r <= pending_count_r;
            endcase
            if (avm_readdatavalid && fifo_empty_s) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule
